// File: rtl/u109_pkg.sv
// Shared definitions for the u109 Amiga/PCI transfer sequencer.
// State encoding, buffer direction codes and the default abort timeout.
package u109_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_TERM,
    S_TURN
  } state_t;

  localparam logic DIR_A2P = 1'b1;
  localparam logic DIR_P2A = 1'b0;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/u109_wait_timer.sv
// Counts DATA-phase cycles without a beat; expire fires on the cycle that
// would bring the count to CYCLES, so a ready beat in that cycle wins.
module u109_wait_timer #(
  parameter int CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + W'(1);
  end

  assign o_expire = i_en && (r_cnt == W'(CYCLES - 1));

endmodule

// File: rtl/u109_xfer_sequencer.sv
// Arbitrates CPU/DMA access to the D<->AD buffers and sequences one
// address phase plus one or four data beats; all outputs registered.
module u109_xfer_sequencer
  import u109_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       CLKP,
  input  logic       RESET,
  input  logic       CPU_REQ,
  input  logic       CPU_RnW,
  input  logic       CPU_LINE,
  input  logic       DMA_REQ,
  input  logic       DMA_RnW,
  input  logic       DMA_LINE,
  input  logic       FIFO_RDY,
  output logic       CPU_GNT,
  output logic       DMA_GNT,
  output logic       ALATCH,
  output logic       DATA_EN,
  output logic       DIRECTION,
  output logic       BEAT_STB,
  output logic [1:0] BEAT_CNT,
  output logic       DONE,
  output logic       TIMEOUT
);

  state_t     r_state, w_state;
  logic       r_cpu_gnt, w_cpu_gnt;
  logic       r_dma_gnt, w_dma_gnt;
  logic       r_dir, w_dir;
  logic       r_alatch, w_alatch;
  logic       r_data_en, w_data_en;
  logic       r_beat, w_beat;
  logic [1:0] r_beat_cnt, w_beat_cnt;
  logic       r_done, w_done;
  logic       r_tmo, w_tmo;
  logic [1:0] r_idx, w_idx;
  logic       r_line, w_line;
  logic       r_last_dma, w_last_dma;
  logic       w_clr, w_en, w_expire;

  u109_wait_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (CLKP),
    .i_rst   (RESET),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state    = r_state;
    w_cpu_gnt  = r_cpu_gnt;
    w_dma_gnt  = r_dma_gnt;
    w_dir      = r_dir;
    w_alatch   = 1'b0;
    w_data_en  = 1'b0;
    w_beat     = 1'b0;
    w_beat_cnt = r_beat_cnt;
    w_done     = 1'b0;
    w_tmo      = 1'b0;
    w_idx      = r_idx;
    w_line     = r_line;
    w_last_dma = r_last_dma;
    w_clr      = 1'b1;
    w_en       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_idx = 2'd0;
        // CPU wins a tie only when DMA was served last
        if (CPU_REQ && (!DMA_REQ || r_last_dma)) begin
          w_cpu_gnt  = 1'b1;
          w_dma_gnt  = 1'b0;
          w_dir      = CPU_RnW ? DIR_P2A : DIR_A2P;
          w_line     = CPU_LINE;
          w_last_dma = 1'b0;
          w_beat_cnt = 2'd0;
          w_state    = S_ADDR;
        end else if (DMA_REQ) begin
          w_cpu_gnt  = 1'b0;
          w_dma_gnt  = 1'b1;
          w_dir      = DMA_RnW ? DIR_A2P : DIR_P2A;
          w_line     = DMA_LINE;
          w_last_dma = 1'b1;
          w_beat_cnt = 2'd0;
          w_state    = S_ADDR;
        end
      end
      S_ADDR: begin
        w_alatch = 1'b1;
        w_state  = S_DATA;
      end
      S_DATA: begin
        w_data_en = 1'b1;
        w_clr     = FIFO_RDY;
        w_en      = !FIFO_RDY;
        if (FIFO_RDY) begin
          w_beat     = 1'b1;
          w_beat_cnt = r_idx;
          if (r_idx == (r_line ? 2'd3 : 2'd0))
            w_state = S_TERM;
          else
            w_idx = r_idx + 2'd1;
        end else if (w_expire) begin
          w_tmo   = 1'b1;
          w_state = S_TERM;
        end
      end
      S_TERM: begin
        w_done  = 1'b1;
        w_state = S_TURN;
      end
      S_TURN: begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        w_dir     = 1'b0;
        w_state   = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKP or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cpu_gnt  <= 1'b0;
      r_dma_gnt  <= 1'b0;
      r_dir      <= 1'b0;
      r_alatch   <= 1'b0;
      r_data_en  <= 1'b0;
      r_beat     <= 1'b0;
      r_beat_cnt <= 2'd0;
      r_done     <= 1'b0;
      r_tmo      <= 1'b0;
      r_idx      <= 2'd0;
      r_line     <= 1'b0;
      r_last_dma <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_cpu_gnt  <= w_cpu_gnt;
      r_dma_gnt  <= w_dma_gnt;
      r_dir      <= w_dir;
      r_alatch   <= w_alatch;
      r_data_en  <= w_data_en;
      r_beat     <= w_beat;
      r_beat_cnt <= w_beat_cnt;
      r_done     <= w_done;
      r_tmo      <= w_tmo;
      r_idx      <= w_idx;
      r_line     <= w_line;
      r_last_dma <= w_last_dma;
    end
  end

  assign CPU_GNT   = r_cpu_gnt;
  assign DMA_GNT   = r_dma_gnt;
  assign DIRECTION = r_dir;
  assign ALATCH    = r_alatch;
  assign DATA_EN   = r_data_en;
  assign BEAT_STB  = r_beat;
  assign BEAT_CNT  = r_beat_cnt;
  assign DONE      = r_done;
  assign TIMEOUT   = r_tmo;

endmodule

// File: tb/tb_u109_xfer_sequencer.sv
// Directed bench for u109_xfer_sequencer: single, line, arbitration,
// timeout, timeout/beat race and mid-burst reset.
module tb_u109_xfer_sequencer;

  logic       CLKP = 1'b0;
  logic       RESET;
  logic       CPU_REQ, CPU_RnW, CPU_LINE;
  logic       DMA_REQ, DMA_RnW, DMA_LINE;
  logic       FIFO_RDY;
  logic       CPU_GNT, DMA_GNT, ALATCH, DATA_EN, DIRECTION;
  logic       BEAT_STB, DONE, TIMEOUT;
  logic [1:0] BEAT_CNT;

  int vectors = 0;
  int miscompares = 0;

  u109_xfer_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .CLKP(CLKP), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_RnW(CPU_RnW), .CPU_LINE(CPU_LINE),
    .DMA_REQ(DMA_REQ), .DMA_RnW(DMA_RnW), .DMA_LINE(DMA_LINE),
    .FIFO_RDY(FIFO_RDY),
    .CPU_GNT(CPU_GNT), .DMA_GNT(DMA_GNT), .ALATCH(ALATCH),
    .DATA_EN(DATA_EN), .DIRECTION(DIRECTION), .BEAT_STB(BEAT_STB),
    .BEAT_CNT(BEAT_CNT), .DONE(DONE), .TIMEOUT(TIMEOUT)
  );

  always #5 CLKP = ~CLKP;

  task automatic tick();
    @(posedge CLKP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] all_out();
    return {CPU_GNT, DMA_GNT, ALATCH, DATA_EN, DIRECTION,
            BEAT_STB, BEAT_CNT, DONE, TIMEOUT};
  endfunction

  int nbeat, ndone, nseq, bad_cnt, early;
  logic dir_seen, gnt_seen, prev_any;
  logic [1:0] order [3];

  initial begin
    RESET = 1'b1;
    {CPU_REQ, CPU_RnW, CPU_LINE} = 3'b000;
    {DMA_REQ, DMA_RnW, DMA_LINE} = 3'b000;
    FIFO_RDY = 1'b0;
    tick();
    tick();
    chk("reset_outs", 32'(all_out()), 32'h0);
    RESET = 1'b0;

    // CPU single read, FIFO always ready
    {CPU_REQ, CPU_RnW, CPU_LINE} = 3'b110;
    FIFO_RDY = 1'b1;
    tick();
    chk("s1_gnt", {CPU_GNT, DMA_GNT, DIRECTION, ALATCH}, 4'b1000);
    CPU_REQ = 1'b0;
    tick();
    chk("s1_alatch", {ALATCH, DATA_EN}, 2'b10);
    tick();
    chk("s1_beat", {BEAT_STB, DATA_EN, BEAT_CNT}, 4'b1100);
    tick();
    chk("s1_done", {DONE, DATA_EN, BEAT_STB, TIMEOUT}, 4'b1000);
    tick();
    chk("s1_turn", {CPU_GNT, DMA_GNT, DATA_EN, ALATCH}, 4'b0000);
    tick();
    chk("s1_idle", 32'(all_out()), 32'h0);

    // DMA line read, FIFO ready every other cycle; LINE dropped mid-way
    {DMA_REQ, DMA_RnW, DMA_LINE} = 3'b111;
    FIFO_RDY = 1'b0;
    nbeat = 0; ndone = 0; dir_seen = 1'b0; gnt_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (DMA_GNT && !gnt_seen) begin
        gnt_seen = 1'b1;
        dir_seen = DIRECTION;
        DMA_REQ  = 1'b0;
        DMA_LINE = 1'b0;
      end
      if (BEAT_STB) begin
        chk("s2_beat_cnt", 32'(BEAT_CNT), 32'(nbeat));
        nbeat++;
      end
      if (DONE) ndone++;
      FIFO_RDY = ~FIFO_RDY;
    end
    chk("s2_granted", 32'(gnt_seen), 32'd1);
    chk("s2_dir", 32'(dir_seen), 32'd1);
    chk("s2_beats", 32'(nbeat), 32'd4);
    chk("s2_dones", 32'(ndone), 32'd1);

    // Both request together, held: CPU, DMA, CPU with TURN gaps
    {CPU_REQ, CPU_RnW, CPU_LINE} = 3'b110;
    {DMA_REQ, DMA_RnW, DMA_LINE} = 3'b110;
    FIFO_RDY = 1'b1;
    nseq = 0; prev_any = 1'b0;
    for (int i = 0; i < 30 && nseq < 3; i++) begin
      tick();
      chk("s3_overlap", 32'(CPU_GNT & DMA_GNT), 32'd0);
      if ((CPU_GNT || DMA_GNT) && !prev_any) begin
        order[nseq] = {CPU_GNT, DMA_GNT};
        nseq++;
      end
      prev_any = CPU_GNT | DMA_GNT;
    end
    CPU_REQ = 1'b0;
    DMA_REQ = 1'b0;
    chk("s3_count", 32'(nseq), 32'd3);
    chk("s3_order", {order[0], order[1], order[2]}, 6'b10_01_10);
    for (int i = 0; i < 8; i++) tick();

    // Timeout: CPU write, FIFO never ready
    {CPU_REQ, CPU_RnW, CPU_LINE} = 3'b100;
    FIFO_RDY = 1'b0;
    tick();
    chk("s4_gnt_dir", {CPU_GNT, DIRECTION}, 2'b11);
    CPU_REQ = 1'b0;
    tick();
    chk("s4_alatch", 32'(ALATCH), 32'd1);
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (TIMEOUT || BEAT_STB || DONE) early++;
    end
    chk("s4_early", 32'(early), 32'd0);
    tick();
    chk("s4_tmo", {TIMEOUT, BEAT_STB, DONE}, 3'b100);
    tick();
    chk("s4_done", {TIMEOUT, BEAT_STB, DONE}, 3'b001);
    for (int i = 0; i < 3; i++) tick();

    // Ready arrives on the expiring cycle: beat wins
    {CPU_REQ, CPU_RnW, CPU_LINE} = 3'b110;
    FIFO_RDY = 1'b0;
    tick();
    CPU_REQ = 1'b0;
    tick();
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (TIMEOUT || BEAT_STB || DONE) early++;
    end
    chk("s6_early", 32'(early), 32'd0);
    FIFO_RDY = 1'b1;
    tick();
    chk("s6_beat", {BEAT_STB, TIMEOUT}, 2'b10);
    FIFO_RDY = 1'b0;
    tick();
    chk("s6_done", {DONE, TIMEOUT}, 2'b10);
    for (int i = 0; i < 3; i++) tick();

    // Reset during beat 2 of a CPU line write
    {CPU_REQ, CPU_RnW, CPU_LINE} = 3'b101;
    FIFO_RDY = 1'b1;
    tick();
    CPU_REQ = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("s5_beat2", {BEAT_STB, BEAT_CNT}, 3'b110);
    #2 RESET = 1'b1;
    #1;
    chk("s5_async", 32'(all_out()), 32'h0);
    tick();
    RESET = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (DONE || TIMEOUT) ndone++;
    end
    chk("s5_no_done", 32'(ndone), 32'd0);

    // Tie after reset: CPU wins, burst restarts at beat 0
    {CPU_REQ, CPU_RnW, CPU_LINE} = 3'b101;
    {DMA_REQ, DMA_RnW, DMA_LINE} = 3'b101;
    tick();
    chk("s5_tie", {CPU_GNT, DMA_GNT}, 2'b10);
    CPU_REQ = 1'b0;
    DMA_REQ = 1'b0;
    tick();
    tick();
    chk("s5_restart", {BEAT_STB, BEAT_CNT}, 3'b100);
    for (int i = 0; i < 8; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
